rtc_field_bank: RTL and testbench

//  Parametrised bank of NUM_FIELDS BCD time/date fields between the RTC multiplexed address/data bus and the VGA layer.

---
 rtl/rtc_field_bank.sv | 184 ++++++++++++++++++
 tb/tb_rtc_field_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_field_bank.sv
// Bank of BCD time/date fields between the RTC multiplexed bus and the display layer.
// Optional auto-repeat on held UP/DOWN is enabled by defining RTC_BANK_AUTOREPEAT_EN.

module rtc_field #(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] MIN    = '0,
    parameter logic [DATA_W-1:0] MAX    = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              inc,
    input  logic              dec,
    input  logic              cap,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              clr,
    output logic [DATA_W-1:0] value,
    output logic              dirty
);
    logic              bad;
    logic [DATA_W-1:0] nxt;

    // Ripple a +1/-1 through the BCD digits.
    function automatic logic [DATA_W-1:0] bcd_step(input logic [DATA_W-1:0] v, input logic up);
        logic [DATA_W-1:0] r;
        logic              c;
        r = v;
        c = 1'b1;
        for (int n = 0; n < DATA_W/4; n++) begin
            if (c) begin
                if (up) begin
                    if (r[4*n+:4] == 4'd9) r[4*n+:4] = 4'd0;
                    else begin r[4*n+:4] = r[4*n+:4] + 4'd1; c = 1'b0; end
                end else begin
                    if (r[4*n+:4] == 4'd0) r[4*n+:4] = 4'd9;
                    else begin r[4*n+:4] = r[4*n+:4] - 4'd1; c = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        bad = (value < MIN) || (value > MAX);
        for (int n = 0; n < DATA_W/4; n++)
            if (value[4*n+:4] > 4'd9) bad = 1'b1;
        if (bad)      nxt = MIN;
        else if (inc) nxt = (value == MAX) ? MIN : bcd_step(value, 1'b1);
        else          nxt = (value == MIN) ? MAX : bcd_step(value, 1'b0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value <= MIN;
            dirty <= 1'b0;
        end else if (inc || dec) begin
            value <= nxt;
            dirty <= 1'b1;
        end else begin
            if (cap && !dirty) value <= cap_data;
            if (clr)           dirty <= 1'b0;
        end
    end
endmodule

module rtc_field_bank #(
    parameter int                           NUM_FIELDS    = 9,
    parameter int                           DATA_W        = 8,
    parameter logic [NUM_FIELDS*8-1:0]      FIELD_ADDR    =
        {8'h41, 8'h42, 8'h43, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26},
    parameter logic [NUM_FIELDS*DATA_W-1:0] FIELD_MIN     =
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00},
    parameter logic [NUM_FIELDS*DATA_W-1:0] FIELD_MAX     =
        {8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99},
    parameter logic [DATA_W-1:0]            UNMAPPED_DATA = 8'hFF,
    parameter logic [23:0]                  REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0]                  REPEAT_PERIOD = 24'd1_000_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         BEnv_Adress,
    input  logic                         BRes_Data,
    input  logic                         BEnv_Data,
    input  logic [7:0]                   Puntero,
    input  logic [7:0]                   ADRESS,
    inout  wire  [DATA_W-1:0]            Multiplex,
    input  logic                         UP,
    input  logic                         DOWN,
    output logic [NUM_FIELDS*DATA_W-1:0] Fields_out,
    output logic [NUM_FIELDS-1:0]        Dirty,
    output logic                         Sel_valid
);
    logic                  up_q, dn_q, up_p, dn_p, rep_up, rep_dn, benv_q;
    logic                  edit_inc, edit_dec, wr_fall;
    logic [NUM_FIELDS-1:0] sel_oh, addr_hit;
    logic [DATA_W-1:0]     wr_data, rd_sel;

    // Reset releases the bus immediately, independent of the FSM flags.
    assign Multiplex = RST         ? {DATA_W{1'bz}} :
                       BEnv_Adress ? DATA_W'(ADRESS) :
                       BEnv_Data   ? wr_data : {DATA_W{1'bz}};

    assign edit_inc = up_p & ~dn_p;
    assign edit_dec = dn_p & ~up_p;
    assign wr_fall  = benv_q & ~BEnv_Data;

    // Descending scan so the lowest matching index wins both decodes.
    always_comb begin
        sel_oh    = '0;
        Sel_valid = 1'b0;
        rd_sel    = UNMAPPED_DATA;
        for (int i = NUM_FIELDS-1; i >= 0; i--) begin
            if (FIELD_ADDR[8*i+:8] == Puntero) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                Sel_valid = 1'b1;
            end
            if (addr_hit[i]) rd_sel = Fields_out[DATA_W*i+:DATA_W];
        end
    end

`ifdef RTC_BANK_AUTOREPEAT_EN
    logic [23:0] up_cnt, dn_cnt;

    assign rep_up = UP & ~DOWN & (up_cnt == REPEAT_DELAY);
    assign rep_dn = DOWN & ~UP & (dn_cnt == REPEAT_DELAY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            up_cnt <= '0;
            dn_cnt <= '0;
        end else begin
            if (!(UP && !DOWN)) up_cnt <= '0;
            else if (rep_up)    up_cnt <= REPEAT_DELAY - REPEAT_PERIOD + 24'd1;
            else                up_cnt <= up_cnt + 24'd1;
            if (!(DOWN && !UP)) dn_cnt <= '0;
            else if (rep_dn)    dn_cnt <= REPEAT_DELAY - REPEAT_PERIOD + 24'd1;
            else                dn_cnt <= dn_cnt + 24'd1;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_up        = 1'b0;
    assign rep_dn        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            up_p    <= 1'b0;
            dn_p    <= 1'b0;
            benv_q  <= 1'b0;
            wr_data <= '0;
        end else begin
            up_q    <= UP;
            dn_q    <= DOWN;
            up_p    <= (UP & ~up_q) | rep_up;
            dn_p    <= (DOWN & ~dn_q) | rep_dn;
            benv_q  <= BEnv_Data;
            wr_data <= rd_sel;
        end
    end

    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
        assign addr_hit[i] = (FIELD_ADDR[8*i+:8] == ADRESS);

        rtc_field #(
            .DATA_W (DATA_W),
            .MIN    (FIELD_MIN[DATA_W*i+:DATA_W]),
            .MAX    (FIELD_MAX[DATA_W*i+:DATA_W])
        ) u_field (
            .CLK      (CLK),
            .RST      (RST),
            .inc      (edit_inc & sel_oh[i]),
            .dec      (edit_dec & sel_oh[i]),
            .cap      (BRes_Data & addr_hit[i]),
            .cap_data (Multiplex),
            .clr      (wr_fall & addr_hit[i]),
            .value    (Fields_out[DATA_W*i+:DATA_W]),
            .dirty    (Dirty[i])
        );
    end
endmodule

// File: tb/tb_rtc_field_bank.sv
// Scoreboard bench for rtc_field_bank: decimal-arithmetic reference model, randomized plus directed stimulus.
module tb_rtc_field_bank;
    localparam int NF  = 9;
    localparam int RDI = 10;
    localparam int RPI = 4;
`ifdef RTC_BANK_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       CLK = 1'b0, RST = 1'b1;
    logic       BEnv_Adress = 1'b0, BRes_Data = 1'b0, BEnv_Data = 1'b0, UP = 1'b0, DOWN = 1'b0;
    logic [7:0] Puntero = 8'h00, ADRESS = 8'h00, tb_bus = 8'h5A;
    wire  [7:0] Multiplex;
    wire        tb_oe = RST | ~(BEnv_Adress | BEnv_Data);
    logic [NF*8-1:0] Fields_out;
    logic [NF-1:0]   Dirty;
    logic            Sel_valid;

    assign Multiplex = tb_oe ? tb_bus : 8'bz;

    rtc_field_bank #(.REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd4)) dut (
        .CLK(CLK), .RST(RST), .BEnv_Adress(BEnv_Adress), .BRes_Data(BRes_Data),
        .BEnv_Data(BEnv_Data), .Puntero(Puntero), .ADRESS(ADRESS), .Multiplex(Multiplex),
        .UP(UP), .DOWN(DOWN), .Fields_out(Fields_out), .Dirty(Dirty), .Sel_valid(Sel_valid)
    );

    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Field map in index order: year, month, day, hour, min, sec, alarm hr/min/sec.
    logic [7:0] addr_t[NF] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
    int         min_d[NF]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    int         max_d[NF]  = '{99, 12, 31, 23, 59, 59, 23, 59, 59};

    logic [7:0] mval[NF];
    bit         mdirty[NF];
    bit         m_upq, m_dnq, m_upp, m_dnp, m_benvq;
    logic [7:0] m_wd;
    int         held_up, held_dn;

    typedef struct {
        int            stamp;
        logic [NF*8-1:0] fields;
        logic [NF-1:0] dirty;
        logic [7:0]    bus;
        logic          sel;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0;

    function automatic int dec_of(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction
    function automatic logic [7:0] to_bcd(int d);
        logic [7:0] r;
        r[7:4] = 4'(d / 10);
        r[3:0] = 4'(d % 10);
        return r;
    endfunction
    function automatic bit bcd_ok(logic [7:0] v, int i);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && dec_of(v) >= min_d[i] && dec_of(v) <= max_d[i];
    endfunction
    function automatic int idx_of(logic [7:0] a);
        for (int i = 0; i < NF; i++) if (addr_t[i] == a) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mval[i]   = to_bcd(min_d[i]);
            mdirty[i] = 1'b0;
        end
        m_upq = 0; m_dnq = 0; m_upp = 0; m_dnp = 0; m_benvq = 0;
        m_wd = 8'h00; held_up = 0; held_dn = 0;
    endtask

    // Advance the model over the coming rising edge, queue what the DUT must show after it.
    task automatic step();
        exp_t       e;
        int         s, a, d;
        logic [7:0] bus_pre, new_wd;
        bit         edited[NF];
        bit         old_dirty[NF];
        bit         rep_u, rep_d;
        if (RST) model_reset();
        else begin
            bus_pre   = BEnv_Adress ? ADRESS : BEnv_Data ? m_wd : tb_bus;
            a         = idx_of(ADRESS);
            new_wd    = (a >= 0) ? mval[a] : 8'hFF;
            old_dirty = mdirty;
            for (int i = 0; i < NF; i++) edited[i] = 1'b0;
            s = idx_of(Puntero);
            if (s >= 0 && m_upp != m_dnp) begin
                d = dec_of(mval[s]);
                if (!bcd_ok(mval[s], s)) mval[s] = to_bcd(min_d[s]);
                else if (m_upp)          mval[s] = to_bcd(d == max_d[s] ? min_d[s] : d + 1);
                else                     mval[s] = to_bcd(d == min_d[s] ? max_d[s] : d - 1);
                mdirty[s] = 1'b1;
                edited[s] = 1'b1;
            end
            for (int i = 0; i < NF; i++) begin
                if (!edited[i] && addr_t[i] == ADRESS) begin
                    if (BRes_Data && !old_dirty[i]) mval[i] = bus_pre;
                    if (m_benvq && !BEnv_Data)      mdirty[i] = 1'b0;
                end
            end
            if (UP && !DOWN) begin
                rep_u = AR && held_up >= RDI && (held_up - RDI) % RPI == 0;
                held_up++;
            end else begin rep_u = 0; held_up = 0; end
            if (DOWN && !UP) begin
                rep_d = AR && held_dn >= RDI && (held_dn - RDI) % RPI == 0;
                held_dn++;
            end else begin rep_d = 0; held_dn = 0; end
            m_upp   = (UP && !m_upq) || rep_u;
            m_dnp   = (DOWN && !m_dnq) || rep_d;
            m_upq   = UP;
            m_dnq   = DOWN;
            m_benvq = BEnv_Data;
            m_wd    = new_wd;
        end
        e.stamp = cyc + 1;
        for (int i = 0; i < NF; i++) begin
            e.fields[8*i+:8] = mval[i];
            e.dirty[i]       = mdirty[i];
        end
        e.bus = RST ? tb_bus : BEnv_Adress ? ADRESS : BEnv_Data ? m_wd : tb_bus;
        e.sel = idx_of(Puntero) >= 0;
        sbq.push_back(e);
        @(negedge CLK);
        #1;
    endtask

    task automatic cmp(string name, logic [NF*8-1:0] act, logic [NF*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whenever an expectation falls due, independent of the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            while (sbq.size() > 0 && sbq[0].stamp <= cyc) begin
                e = sbq.pop_front();
                cmp("fields", Fields_out, e.fields);
                cmp("dirty", {{(NF*8-NF){1'b0}}, Dirty}, {{(NF*8-NF){1'b0}}, e.dirty});
                cmp("bus", {{(NF*8-8){1'b0}}, Multiplex}, {{(NF*8-8){1'b0}}, e.bus});
                cmp("sel_valid", {{(NF*8-1){1'b0}}, Sel_valid}, {{(NF*8-1){1'b0}}, e.sel});
            end
        end
    end

    initial begin
        model_reset();
        // Reset: bus must be released even with BEnv_Adress high.
        RST = 1; BEnv_Adress = 1; ADRESS = 8'h21; tb_bus = 8'h5A;
        @(negedge CLK); #1;
        step(); step();
        RST = 0; BEnv_Adress = 0;
        repeat (10) step();
        // Minutes: load 59, UP wraps to 00, DOWN back to 59, UP+DOWN no change.
        ADRESS = 8'h22; BRes_Data = 1; tb_bus = 8'h59; step();
        BRes_Data = 0; ADRESS = 8'h10; Puntero = 8'h22;
        UP = 1; step(); UP = 0; repeat (3) step();
        DOWN = 1; step(); DOWN = 0; repeat (3) step();
        UP = 1; DOWN = 1; step(); UP = 0; DOWN = 0; repeat (3) step();
        // Seconds: capture, edit, blocked capture, dirty clear, capture again.
        ADRESS = 8'h21; BRes_Data = 1; tb_bus = 8'h37; step(); BRes_Data = 0;
        Puntero = 8'h21; UP = 1; step(); UP = 0; step(); step();
        BRes_Data = 1; tb_bus = 8'h10; step(); BRes_Data = 0;
        BEnv_Data = 1; step(); step(); BEnv_Data = 0; step(); step();
        BRes_Data = 1; tb_bus = 8'h45; step(); BRes_Data = 0; step();
        // Write data: mapped, unmapped, and address priority over data.
        ADRESS = 8'h24; BEnv_Data = 1; step(); step();
        ADRESS = 8'h10; step(); step();
        BEnv_Adress = 1; step(); BEnv_Adress = 0; BEnv_Data = 0; step();
        // Edit and capture colliding on hours, then reset mid-transfer.
        Puntero = 8'h23; UP = 1; step();
        UP = 0; ADRESS = 8'h23; BRes_Data = 1; tb_bus = 8'h11; step(); BRes_Data = 0; step();
        BEnv_Data = 1; ADRESS = 8'h24; step();
        RST = 1; BEnv_Adress = 1; step(); step();
        RST = 0; BEnv_Adress = 0; BEnv_Data = 0; step();
        // Long hold on year.
        Puntero = 8'h26; UP = 1; repeat (30) step(); UP = 0; repeat (4) step();
        // Randomized traffic.
        repeat (1500) begin
            if ($urandom_range(0, 9) == 0) UP = ~UP;
            if ($urandom_range(0, 9) == 0) DOWN = ~DOWN;
            if ($urandom_range(0, 19) == 0)
                Puntero = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addr_t[$urandom_range(0, NF-1)];
            ADRESS      = ($urandom_range(0, 4) == 0) ? 8'($urandom) : addr_t[$urandom_range(0, NF-1)];
            BEnv_Adress = ($urandom_range(0, 9) == 0);
            BEnv_Data   = ($urandom_range(0, 3) == 0);
            BRes_Data   = ($urandom_range(0, 3) == 0);
            tb_bus      = ($urandom_range(0, 1) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 59));
            RST         = ($urandom_range(0, 299) == 0);
            step();
        end
        RST = 0; UP = 0; DOWN = 0; BEnv_Adress = 0; BEnv_Data = 0; BRes_Data = 0;
        repeat (4) step();
        repeat (3) @(negedge CLK);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
